imem_responder: RTL and testbench

- Instruction-memory responder that serves fetch requests issued by the Stage 1 (fetch) logic of the pipelined MIPS core.
- Holds a word-addressed instruction store and answers one request at a time over a req/ack handshake, with a configurable wait-state count.
- A response backpressures until the fetch/decode side accepts it.
- A separate load port writes the program before or between runs.

---
 rtl/imem_responder.sv | 161 ++++++++++++++++
 tb/tb_imem_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage: one outstanding request, fixed wait states,
// backpressured response. Define IMEM_RESP_COUNT_EN to add resp_count/err_count outputs.
module imem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [31:0]   req_addr,
    output logic          req_ready,
    input  logic          flush,
    output logic          rsp_valid,
    output logic [31:0]   rsp_instr,
    output logic [31:0]   rsp_addr,
    output logic          rsp_err,
    input  logic          rsp_ready,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data
`ifdef IMEM_RESP_COUNT_EN
    ,
    output logic [31:0]   resp_count,
    output logic [15:0]   err_count
`endif
);
    // Handshake: a request transfers on a clock edge with req_valid && req_ready && !flush;
    // a response transfers on an edge with rsp_valid && rsp_ready && !flush.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    logic [31:0] mem [DEPTH_WORDS];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic        enter_resp;

    logic [31:0]   rd_addr;
    logic [AW-1:0] rd_idx;
    logic          rd_err;
    logic [31:0]   rd_word;

    // With zero wait states the read happens on the accept edge, before addr_q is loaded.
    always_comb begin
        rd_addr = (state_q == S_IDLE) ? req_addr : addr_q;
        rd_idx  = rd_addr[AW+1:2];
        rd_err  = (rd_addr[1:0] != 2'b00) || (rd_addr[31:AW+2] != '0);
        rd_word = (ld_en && (ld_addr == rd_idx)) ? ld_data : mem[rd_idx];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    addr_d = req_addr;
                    cnt_d  = WAIT_LD;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (flush || rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (enter_resp) begin
            instr_d = rd_err ? NOP_WORD : rd_word;
            err_d   = rd_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            instr_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    // Program load is independent of reset so a program can be written while held in reset.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_instr = instr_q;
    assign rsp_addr  = addr_q;
    assign rsp_err   = err_q;

`ifdef IMEM_RESP_COUNT_EN
    logic [31:0] resp_count_q, resp_count_d;
    logic [15:0] err_count_q, err_count_d;
    logic        consume;

    always_comb begin
        consume      = (state_q == S_RESP) && rsp_ready && !flush;
        resp_count_d = resp_count_q;
        err_count_d  = err_count_q;
        if (consume) begin
            resp_count_d = resp_count_q + 32'd1;
            if (err_q) err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_count_q <= 32'd0;
            err_count_q  <= 16'd0;
        end else begin
            resp_count_q <= resp_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign resp_count = resp_count_q;
    assign err_count  = err_count_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: a 2-wait-state instance for the main scenarios and a
// zero-wait instance for the minimum-latency case; expected responses go through a scoreboard.
module tb_imem_responder;
    localparam int W_MAIN = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        rsp_ready = 1'b0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = 8'd0;
    logic [31:0] ld_data = 32'd0;

    logic        z_req_valid = 1'b0;
    logic [31:0] z_req_addr = 32'd0;
    logic        z_req_ready;
    logic        z_flush = 1'b0;
    logic        z_rsp_valid;
    logic [31:0] z_rsp_instr;
    logic [31:0] z_rsp_addr;
    logic        z_rsp_err;
    logic        z_rsp_ready = 1'b0;

`ifdef IMEM_RESP_COUNT_EN
    logic [31:0] resp_count, z_resp_count;
    logic [15:0] err_count, z_err_count;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int exp_resp = 0;
    int exp_err = 0;

    logic [31:0] model_mem [256];
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_addr_q[$];
    logic        exp_err_q[$];

    imem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W_MAIN), .NOP_WORD(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .flush(flush), .rsp_valid(rsp_valid), .rsp_instr(rsp_instr),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef IMEM_RESP_COUNT_EN
        , .resp_count(resp_count), .err_count(err_count)
`endif
    );

    imem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .NOP_WORD(32'h0000_0000)) dut0 (
        .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_addr(z_req_addr),
        .req_ready(z_req_ready), .flush(z_flush), .rsp_valid(z_rsp_valid),
        .rsp_instr(z_rsp_instr), .rsp_addr(z_rsp_addr), .rsp_err(z_rsp_err),
        .rsp_ready(z_rsp_ready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef IMEM_RESP_COUNT_EN
        , .resp_count(z_resp_count), .err_count(z_err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] idx, input logic [31:0] data);
        ld_en = 1'b1;
        ld_addr = idx;
        ld_data = data;
        model_mem[idx] = data;
        step();
        ld_en = 1'b0;
    endtask

    task automatic push_expected(input logic [31:0] addr);
        logic e;
        e = (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
        exp_instr_q.push_back(e ? 32'h0000_0000 : model_mem[addr[9:2]]);
        exp_addr_q.push_back(addr);
        exp_err_q.push_back(e);
    endtask

    // One full transaction on the main instance; an optional load is driven in WAIT cycle ld_cyc.
    task automatic fetch(input logic [31:0] addr, input int stall, input int ld_cyc,
                         input logic [7:0] li, input logic [31:0] ld);
        int lat;
        logic [31:0] e_instr, e_addr;
        logic e_err;
        if (ld_cyc > 0) model_mem[li] = ld;
        push_expected(addr);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_req addr=%h got=%b want=1", addr, req_ready);
        end
        req_valid = 1'b1;
        req_addr = addr;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        lat = 1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_accept addr=%h got=%b want=0", addr, req_ready);
        end
        while (rsp_valid !== 1'b1 && lat < 40) begin
            if (lat == ld_cyc) begin
                ld_en = 1'b1;
                ld_addr = li;
                ld_data = ld;
            end
            step();
            ld_en = 1'b0;
            lat++;
        end
        e_instr = exp_instr_q.pop_front();
        e_addr = exp_addr_q.pop_front();
        e_err = exp_err_q.pop_front();
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_timeout addr=%h got=%b want=1", addr, rsp_valid);
            return;
        end
        n_cmp++;
        if (lat != W_MAIN + 1) begin
            n_fail++;
            $display("FAIL latency addr=%h got=%0d want=%0d", addr, lat, W_MAIN + 1);
        end
        for (int i = 0; i <= stall; i++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_instr !== e_instr || rsp_addr !== e_addr ||
                rsp_err !== e_err || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL response addr=%h cyc=%0d got v=%b i=%h a=%h e=%b rr=%b want v=1 i=%h a=%h e=%b rr=0",
                         addr, i, rsp_valid, rsp_instr, rsp_addr, rsp_err, req_ready,
                         e_instr, e_addr, e_err);
            end
            if (i < stall) step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_resp++;
        if (e_err) exp_err++;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_consume addr=%h got v=%b rr=%b want v=0 rr=1",
                     addr, rsp_valid, req_ready);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_instr !== 32'd0 ||
            rsp_addr !== 32'd0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s got rr=%b v=%b i=%h a=%h e=%b want all zero",
                     tag, req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err);
        end
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (rsp_valid !== 1'b0) seen++;
            step();
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL %s got %0d valid cycles want 0", tag, seen);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
        reset = 1'b1;
        step();
        load(8'd0, 32'h2008_0005);
        load(8'd1, 32'h2009_0003);
        load(8'd2, 32'h0109_5020);
        load(8'd3, 32'h0000_0000);
        check_reset_outputs("reset_outputs");
        reset = 1'b0;
        step();
        n_cmp++;
        if (req_ready !== 1'b1 || z_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset got=%b/%b want=1/1", req_ready, z_req_ready);
        end
    endtask

    task automatic test_basic();
        fetch(32'h0, 0, 0, 8'd0, 32'd0);
        fetch(32'h4, 0, 0, 8'd0, 32'd0);
    endtask

    task automatic test_stall();
        fetch(32'h8, 5, 0, 8'd0, 32'd0);
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 1'b1;
        req_addr = 32'h8;
        step();
        req_valid = 1'b0;
        reset = 1'b1;
        step();
        check_reset_outputs("reset_mid_wait");
        step();
        check_reset_outputs("reset_hold");
        reset = 1'b0;
        exp_resp = 0;
        exp_err = 0;
        expect_quiet("stale_after_reset", 6);
        fetch(32'h4, 0, 0, 8'd0, 32'd0);
    endtask

    task automatic test_errors();
        fetch(32'h6, 0, 0, 8'd0, 32'd0);
        fetch(32'h400, 1, 0, 8'd0, 32'd0);
    endtask

    task automatic test_flush();
        int lat;
        req_valid = 1'b1;
        req_addr = 32'hC;
        step();
        req_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_wait_ready got=%b want=1", req_ready);
        end
        expect_quiet("flush_wait_no_rsp", 6);
        fetch(32'h0, 0, 0, 8'd0, 32'd0);

        req_valid = 1'b1;
        req_addr = 32'h4;
        flush = 1'b1;
        step();
        req_valid = 1'b0;
        flush = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_idle_blocks got ready=%b want=1", req_ready);
        end
        expect_quiet("flush_idle_no_rsp", 6);

        req_valid = 1'b1;
        req_addr = 32'h4;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_resp_setup got=%b want=1", rsp_valid);
        end
        flush = 1'b1;
        rsp_ready = 1'b1;
        step();
        flush = 1'b0;
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_resp_drop got v=%b rr=%b want v=0 rr=1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_load_hazard();
        fetch(32'h4, 0, 1, 8'd1, 32'hDEAD_BEEF);
        fetch(32'h8, 0, 2, 8'd2, 32'hCAFE_F00D);
    endtask

    task automatic test_zero_wait();
        logic [31:0] e_instr, e_addr;
        logic e_err;
        push_expected(32'h4);
        e_instr = exp_instr_q.pop_front();
        e_addr = exp_addr_q.pop_front();
        e_err = exp_err_q.pop_front();
        z_req_valid = 1'b1;
        z_req_addr = 32'h4;
        step();
        z_req_valid = 1'b0;
        n_cmp++;
        if (z_rsp_valid !== 1'b1 || z_rsp_instr !== e_instr || z_rsp_addr !== e_addr ||
            z_rsp_err !== e_err) begin
            n_fail++;
            $display("FAIL zero_wait got v=%b i=%h a=%h e=%b want v=1 i=%h a=%h e=%b",
                     z_rsp_valid, z_rsp_instr, z_rsp_addr, z_rsp_err, e_instr, e_addr, e_err);
        end
        z_rsp_ready = 1'b1;
        step();
        z_rsp_ready = 1'b0;
        n_cmp++;
        if (z_rsp_valid !== 1'b0 || z_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_wait_consume got v=%b rr=%b want v=0 rr=1", z_rsp_valid, z_req_ready);
        end
    endtask

`ifdef IMEM_RESP_COUNT_EN
    task automatic test_counters();
        n_cmp++;
        if (resp_count !== 32'(exp_resp) || err_count !== 16'(exp_err)) begin
            n_fail++;
            $display("FAIL counters got resp=%0d err=%0d want resp=%0d err=%0d",
                     resp_count, err_count, exp_resp, exp_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid_wait();
        test_errors();
        test_flush();
        test_load_hazard();
        test_zero_wait();
`ifdef IMEM_RESP_COUNT_EN
        test_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
